// File: rtl/accum_pkg.sv
// Shared defaults and state encoding for the windowed accumulate / round / saturate block.
package accum_pkg;

    localparam int DEF_BIT   = 40;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

endpackage : accum_pkg

// File: rtl/round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed saturation of a window sum.
module round_sat
    import accum_pkg::*;
#(
    parameter int ACC_W = DEF_BIT + DEF_CNT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    // One guard bit so adding the rounding constant cannot wrap a near-maximum sum.
    localparam int EXT_W = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] HALF  = {{(EXT_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        biased  = {acc_i[ACC_W-1], acc_i} + HALF;
        shifted = biased >>> SHIFT;
        data_o  = shifted[OUT_W-1:0];
        sat_o   = 1'b0;
        if (shifted > MAX_V) begin
            data_o = MAX_V[OUT_W-1:0];
            sat_o  = 1'b1;
        end else if (shifted < MIN_V) begin
            data_o = MIN_V[OUT_W-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule : round_sat

// File: rtl/accum_round_sat.sv
// Sums len_in signed samples per window, then rounds, saturates and registers the result.
module accum_round_sat
    import accum_pkg::*;
#(
    parameter int BIT   = DEF_BIT,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = BIT + CNT_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in_valid,
    input  logic [BIT-1:0]   data_in,
    input  logic [CNT_W-1:0] len_in,
    input  logic             clear,
    output logic             data_out_valid,
    output logic [OUT_W-1:0] data_out,
    output logic             sat_out
);

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] len_q,   len_d;
    logic             done_q,  done_d;
    logic             valid_q;
    logic [OUT_W-1:0] dout_q;
    logic             sat_q;

    logic [ACC_W-1:0] sample_ext;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic [OUT_W-1:0] rs_data;
    logic             rs_sat;

    assign sample_ext = ACC_W'($signed(data_in));
    assign len_eff    = (len_in == '0) ? CNT_W'(1) : len_in;
    assign cnt_inc    = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (data_in_valid) begin
            if (state_q == IDLE) begin
                acc_d = sample_ext;
                len_d = len_eff;
                if (len_eff == CNT_W'(1)) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    state_d = ACCUM;
                    cnt_d   = CNT_W'(1);
                end
            end else begin
                acc_d = acc_q + sample_ext;
                if (cnt_inc == len_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc_i  (acc_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    // acc_q still holds the closed sum here even if a new window loads on this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= done_q;
            if (done_q) begin
                dout_q <= rs_data;
                sat_q  <= rs_sat;
            end
        end
    end

    assign data_out_valid = valid_q;
    assign data_out       = dout_q;
    assign sat_out        = sat_q;

endmodule : accum_round_sat
